// File: rtl/router_pkt_sink.sv
// Downstream sink for one router output port: drains the port FIFO, reassembles
// header/payload/parity, forwards payload bytes and reports per-packet status.
module router_pkt_sink #(
  parameter logic [1:0] PORT_ADDR = 2'b00,
  parameter int         ABORT_CYC = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vld_out,
  input  logic [7:0]  data_out,
  output logic        read_enb,
  input  logic        sink_ready,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        byte_sop,
  output logic        byte_eop,
  output logic        pkt_done,
  output logic        pkt_err,
  output logic [2:0]  err_code,
  output logic [5:0]  pkt_len,
  output logic [15:0] pkt_count,
  output logic [15:0] err_count
);

  localparam int IW = $clog2(ABORT_CYC + 1);

  typedef enum logic [2:0] {IDLE, HDR, PLD, PAR, DONE} state_t;

  state_t        state;
  logic          rd_d1;
  logic [6:0]    remaining;
  logic [5:0]    len;
  logic [5:0]    pld_cnt;
  logic [7:0]    acc;
  logic          addr_err;
  logic [IW-1:0] idle_cnt;
  logic          in_pkt;
  logic          abort_now;

  // remaining counts issued reads (payload + parity), so reads stop exactly
  // at the packet boundary even though captures lag one cycle behind
  assign read_enb = vld_out && sink_ready &&
                    ((state == IDLE) || ((state == PLD) && (remaining != 7'd0)));

  assign in_pkt    = (state == HDR) || (state == PLD) || (state == PAR);
  assign abort_now = in_pkt && !rd_d1 && (idle_cnt == IW'(ABORT_CYC - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rd_d1      <= 1'b0;
      remaining  <= '0;
      len        <= '0;
      pld_cnt    <= '0;
      acc        <= '0;
      addr_err   <= 1'b0;
      idle_cnt   <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      byte_sop   <= 1'b0;
      byte_eop   <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_err    <= 1'b0;
      err_code   <= '0;
      pkt_len    <= '0;
      pkt_count  <= '0;
      err_count  <= '0;
    end else begin
      rd_d1      <= read_enb;
      byte_valid <= 1'b0;
      byte_sop   <= 1'b0;
      byte_eop   <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_err    <= 1'b0;
      err_code   <= '0;

      if ((state == PLD) && read_enb)
        remaining <= remaining - 7'd1;

      if (in_pkt)
        idle_cnt <= rd_d1 ? '0 : idle_cnt + IW'(1);
      else
        idle_cnt <= '0;

      // Abort means the router has soft-reset the FIFO; nothing more will come
      if (abort_now) begin
        pkt_done <= 1'b1;
        pkt_err  <= 1'b1;
        err_code <= {1'b1, addr_err, 1'b0};
        if (err_count != 16'hFFFF)
          err_count <= err_count + 16'd1;
        state <= DONE;
      end else begin
        case (state)
          IDLE: begin
            addr_err <= 1'b0;
            if (read_enb)
              state <= HDR;
          end
          HDR: begin
            if (rd_d1) begin
              len       <= data_out[7:2];
              pkt_len   <= data_out[7:2];
              addr_err  <= (data_out[1:0] != PORT_ADDR);
              acc       <= data_out;
              remaining <= {1'b0, data_out[7:2]} + 7'd1;
              pld_cnt   <= '0;
              state     <= PLD;
            end
          end
          PLD: begin
            if (rd_d1) begin
              acc <= acc ^ data_out;
              if (pld_cnt == len) begin
                state <= PAR;
              end else begin
                byte_valid <= 1'b1;
                byte_data  <= data_out;
                byte_sop   <= (pld_cnt == 6'd0);
                byte_eop   <= (pld_cnt == len - 6'd1);
                pld_cnt    <= pld_cnt + 6'd1;
              end
            end
          end
          PAR: begin
            pkt_done <= 1'b1;
            pkt_err  <= addr_err || (acc != 8'd0);
            err_code <= {1'b0, addr_err, (acc != 8'd0)};
            if (addr_err || (acc != 8'd0)) begin
              if (err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
            end else begin
              if (pkt_count != 16'hFFFF)
                pkt_count <= pkt_count + 16'd1;
            end
            state <= DONE;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
